// File: rtl/rx_4b.sv
// rx_4b: 4-bit SPI receive front end.
// Oversamples spi_clk/spi_w/mosi in the clk domain, assembles NIBBLES nibbles
// (MSB nibble first) into one frame and offers it to the ALU over valid/ready.
module rx_4b #(
   parameter int NIBBLES     = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   spi_clk,
   input  logic                   spi_w,
   input  logic [3:0]             mosi,
   output logic [4*NIBBLES-1:0]   rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic                   rx_busy,
   output logic                   frame_err,
   output logic                   overrun
);

   localparam int            FW   = 4 * NIBBLES;
   localparam int            CW   = $clog2(NIBBLES);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RECV = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   // synchroniser chains, newest sample in bit/element 0
   logic [SYNC_STAGES-1:0]      sclk_sync_q;
   logic [SYNC_STAGES-1:0]      w_sync_q;
   logic [SYNC_STAGES-1:0][3:0] mosi_sync_q;

   // edge-detect stage: edge flag plus spi_w and mosi delayed to stay aligned with it
   logic       sclk_prev_q;
   logic       edge_q;
   logic       w_q;
   logic [3:0] nib_q;

   // frame assembly
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [FW-5:0] shreg_q, shreg_d;
   logic [FW-1:0] frame_q, frame_d;
   logic          done_q, done_d;
   logic          err_d;
   logic [FW-1:0] shifted;

   // output stage
   logic [FW-1:0] rx_data_q;
   logic          rx_valid_q;
   logic          frame_err_q;
   logic          overrun_q;

   // bring the asynchronous SPI pins into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         w_sync_q    <= '0;
         mosi_sync_q <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
         w_sync_q    <= {w_sync_q[SYNC_STAGES-2:0], spi_w};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      end
   end

   // registered rising-edge detection on the synchronised spi_clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_prev_q <= 1'b0;
         edge_q      <= 1'b0;
         w_q         <= 1'b0;
         nib_q       <= '0;
      end else begin
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         edge_q      <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
         w_q         <= w_sync_q[SYNC_STAGES-1];
         nib_q       <= mosi_sync_q[SYNC_STAGES-1];
      end
   end

   assign shifted = {shreg_q, nib_q};

   // frame FSM: counts qualified edges inside one spi_w window
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      shreg_d = shreg_q;
      frame_d = frame_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_q) begin
               state_d = S_RECV;
               count_d = '0;
               // an edge arriving together with the window opening is kept
               if (edge_q) begin
                  shreg_d = shifted[FW-5:0];
                  count_d = CW'(1);
               end
            end
         end
         S_RECV: begin
            if (!w_q) begin
               state_d = S_IDLE;
               count_d = '0;
               err_d   = (count_q != '0);
            end else if (edge_q) begin
               if (count_q == LAST) begin
                  frame_d = shifted;
                  done_d  = 1'b1;
                  count_d = '0;
                  state_d = S_WAIT;
               end else begin
                  shreg_d = shifted[FW-5:0];
                  count_d = count_q + CW'(1);
               end
            end
         end
         S_WAIT: begin
            if (!w_q) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            count_d = '0;
         end
      endcase
   end

   // FSM and assembly registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         shreg_q <= '0;
         frame_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         shreg_q <= shreg_d;
         frame_q <= frame_d;
         done_q  <= done_d;
      end
   end

   // output holding register with valid/ready handshake and overrun detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= err_d;
         overrun_q   <= 1'b0;
         if (done_q) begin
            if (!rx_valid_q || rx_ready) begin
               rx_data_q  <= frame_q;
               rx_valid_q <= 1'b1;
            end else begin
               overrun_q  <= 1'b1;
            end
         end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign rx_busy   = (state_q == S_RECV);
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_rx_4b.sv
// tb_rx_4b: table-driven and randomized bench for rx_4b (default parameters).
module tb_rx_4b;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        spi_clk;
   logic        spi_w;
   logic [3:0]  mosi;
   logic [19:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        rx_busy;
   logic        frame_err;
   logic        overrun;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int err_cnt  = 0;
   int ovr_cnt  = 0;

   typedef struct {
      int          n;
      logic [31:0] nibs;
      bit          consume;
      logic [19:0] exp_data;
      bit          exp_valid;
      int          exp_err;
      int          exp_ovr;
   } vec_t;

   vec_t tbl [6];

   rx_4b #(.NIBBLES(5), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_clk   (spi_clk),
      .spi_w     (spi_w),
      .mosi      (mosi),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_busy   (rx_busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // pulse counters, one count per clk cycle the pulse is high
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err) err_cnt++;
         if (overrun)   ovr_cnt++;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic send_nib(input logic [3:0] n);
      mosi = n;
      cyc(4);
      spi_clk = 1'b1;
      cyc(4);
      spi_clk = 1'b0;
   endtask

   task automatic w_on();
      spi_w = 1'b1;
      cyc(4);
   endtask

   task automatic w_off();
      cyc(4);
      spi_w = 1'b0;
      cyc(10);
   endtask

   task automatic send_window(input int n, input logic [31:0] nibs);
      w_on();
      for (int i = 0; i < n; i++) send_nib(nibs[31-4*i -: 4]);
      w_off();
   endtask

   task automatic consume();
      rx_ready = 1'b1;
      cyc(1);
      rx_ready = 1'b0;
   endtask

   initial begin
      int          e0, o0;
      int          n;
      bit          cons;
      logic [31:0] nibs;
      logic [19:0] frame;
      logic [19:0] m_data;
      bit          m_valid;
      int          m_err, m_ovr;

      tbl[0] = '{5, 32'h12345000, 1'b0, 20'h12345, 1'b1, 0, 0};
      tbl[1] = '{5, 32'hFEDCB000, 1'b1, 20'h12345, 1'b1, 0, 1};
      tbl[2] = '{3, 32'h12300000, 1'b0, 20'h12345, 1'b0, 1, 0};
      tbl[3] = '{5, 32'hABCDE000, 1'b1, 20'hABCDE, 1'b1, 0, 0};
      tbl[4] = '{7, 32'h12345670, 1'b1, 20'h12345, 1'b1, 0, 0};
      tbl[5] = '{0, 32'h00000000, 1'b0, 20'h12345, 1'b0, 0, 0};

      rst_n = 1'b0; spi_clk = 1'b0; spi_w = 1'b0; mosi = 4'h0; rx_ready = 1'b0;
      cyc(3);
      chk("reset rx_data", 32'(rx_data), 32'h0);
      chk("reset rx_valid", 32'(rx_valid), 32'h0);
      chk("reset rx_busy", 32'(rx_busy), 32'h0);
      chk("reset frame_err", 32'(frame_err), 32'h0);
      chk("reset overrun", 32'(overrun), 32'h0);
      rst_n = 1'b1;
      cyc(3);

      // first frame with exact latency of the final nibble
      w_on();
      send_nib(4'h3); send_nib(4'hA); send_nib(4'h5); send_nib(4'h5);
      chk("busy mid-frame", 32'(rx_busy), 32'h1);
      mosi = 4'hA;
      cyc(4);
      spi_clk = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk($sformatf("latency valid low edge %0d", i), 32'(rx_valid), 32'h0);
      end
      cyc(1);
      chk("latency valid high", 32'(rx_valid), 32'h1);
      chk("latency rx_data", 32'(rx_data), 32'h3A55A);
      spi_clk = 1'b0;
      w_off();
      consume();
      chk("first transfer valid low", 32'(rx_valid), 32'h0);

      // table of whole-window vectors
      for (int v = 0; v < 6; v++) begin
         e0 = err_cnt; o0 = ovr_cnt;
         send_window(tbl[v].n, tbl[v].nibs);
         chk($sformatf("tbl%0d rx_valid", v), 32'(rx_valid), 32'(tbl[v].exp_valid));
         chk($sformatf("tbl%0d rx_data", v), 32'(rx_data), 32'(tbl[v].exp_data));
         chk($sformatf("tbl%0d frame_err", v), 32'(err_cnt - e0), 32'(tbl[v].exp_err));
         chk($sformatf("tbl%0d overrun", v), 32'(ovr_cnt - o0), 32'(tbl[v].exp_ovr));
         chk($sformatf("tbl%0d rx_busy", v), 32'(rx_busy), 32'h0);
         if (tbl[v].consume) begin
            consume();
            chk($sformatf("tbl%0d consumed", v), 32'(rx_valid), 32'h0);
         end
      end

      // spi_clk toggling outside a window does nothing
      e0 = err_cnt;
      for (int i = 0; i < 3; i++) begin
         mosi = 4'(i + 7);
         cyc(4); spi_clk = 1'b1; cyc(4); spi_clk = 1'b0;
      end
      cyc(8);
      chk("idle toggle rx_valid", 32'(rx_valid), 32'h0);
      chk("idle toggle rx_data", 32'(rx_data), 32'h12345);
      chk("idle toggle frame_err", 32'(err_cnt - e0), 32'h0);

      // ready pulsed exactly when a new frame completes
      send_window(5, 32'h12345000);
      o0 = ovr_cnt;
      w_on();
      send_nib(4'h0); send_nib(4'h0); send_nib(4'h0); send_nib(4'h0);
      mosi = 4'h1;
      cyc(4);
      spi_clk = 1'b1;
      cyc(4);
      chk("same-cycle old valid", 32'(rx_valid), 32'h1);
      chk("same-cycle old data", 32'(rx_data), 32'h12345);
      rx_ready = 1'b1;
      cyc(1);
      rx_ready = 1'b0;
      chk("same-cycle valid kept", 32'(rx_valid), 32'h1);
      chk("same-cycle new data", 32'(rx_data), 32'h00001);
      cyc(3);
      spi_clk = 1'b0;
      w_off();
      chk("same-cycle no overrun", 32'(ovr_cnt - o0), 32'h0);
      consume();
      chk("same-cycle consumed", 32'(rx_valid), 32'h0);

      // asynchronous reset in the middle of a frame
      send_window(5, 32'h55555000);
      w_on();
      send_nib(4'h9); send_nib(4'h8);
      chk("pre-reset busy", 32'(rx_busy), 32'h1);
      chk("pre-reset valid", 32'(rx_valid), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset rx_data", 32'(rx_data), 32'h0);
      chk("async reset rx_valid", 32'(rx_valid), 32'h0);
      chk("async reset rx_busy", 32'(rx_busy), 32'h0);
      spi_w = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(3);
      e0 = err_cnt;
      send_window(5, 32'h0F0F0000);
      chk("post-reset rx_valid", 32'(rx_valid), 32'h1);
      chk("post-reset rx_data", 32'(rx_data), 32'h0F0F0);
      chk("post-reset frame_err", 32'(err_cnt - e0), 32'h0);
      consume();
      chk("post-reset consumed", 32'(rx_valid), 32'h0);

      // randomized windows against a transaction-level model
      m_valid = 1'b0; m_data = 20'h0F0F0;
      for (int w = 0; w < 40; w++) begin
         n    = $urandom_range(0, 7);
         nibs = $urandom;
         cons = 1'($urandom_range(0, 1));
         m_err = 0; m_ovr = 0;
         if (n >= 5) begin
            frame = 20'h0;
            for (int i = 0; i < 5; i++) frame = (frame << 4) | 20'(nibs[31-4*i -: 4]);
            if (m_valid) m_ovr = 1;
            else begin
               m_data  = frame;
               m_valid = 1'b1;
            end
         end else if (n >= 1) begin
            m_err = 1;
         end
         e0 = err_cnt; o0 = ovr_cnt;
         send_window(n, nibs);
         chk($sformatf("rnd%0d rx_valid", w), 32'(rx_valid), 32'(m_valid));
         chk($sformatf("rnd%0d rx_data", w), 32'(rx_data), 32'(m_data));
         chk($sformatf("rnd%0d frame_err", w), 32'(err_cnt - e0), 32'(m_err));
         chk($sformatf("rnd%0d overrun", w), 32'(ovr_cnt - o0), 32'(m_ovr));
         if (cons) begin
            consume();
            if (m_valid) begin
               m_valid = 1'b0;
               chk($sformatf("rnd%0d consumed", w), 32'(rx_valid), 32'h0);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/rx_4b.md
Name: rx_4b

Overview:
- 4-bit-wide SPI receive front end: deserialises a command frame sent by the external master on a 4-bit MOSI bus.
- Presents the assembled frame to the ALU/decoder through a valid/ready handshake.
- Mirror of the TX path: the host writes opcode and operands through this block and reads results back through the TX block.
- Frame layout with default parameters: 20 bits = 5 nibbles; [19:16] opcode, [15:8] operand A, [7:0] operand B; MSB nibble first.

Parameters:
- NIBBLES, 5, nibbles per frame; legal range 2..16.
- SYNC_STAGES, 2, synchroniser depth applied to spi_clk, spi_w and mosi; minimum 2.

Ports:
- clk  input  1  system clock; sole clock of the block.
- rst_n  input  1  asynchronous active-low reset.
- spi_clk  input  1  SPI clock from the master, asynchronous to clk and oversampled.
- spi_w  input  1  SPI write enable; frame window while high.
- mosi  input  4  nibble data, valid on spi_clk rising edge.
- rx_data  output  4*NIBBLES  assembled frame, held stable while rx_valid is high.
- rx_valid  output  1  frame available to the ALU.
- rx_ready  input  1  ALU accepts the frame.
- rx_busy  output  1  high while in RECV.
- frame_err  output  1  one-cycle pulse: frame aborted early.
- overrun  output  1  one-cycle pulse: completed frame dropped.

Behaviour:
- Reset (async assert, sync release): rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, nibble count=0, FSM=IDLE, all synchroniser flops=0.
- Synchronisation: spi_clk, spi_w and mosi each pass through SYNC_STAGES flops.
- Edge detection: an edge is the synced spi_clk=1 while its previous sample was 0. Detection is registered; no logic runs on the spi_clk net.
- Edge qualification: an edge counts only if synced spi_w=1 in the same clk cycle. Edges while spi_w=0 are ignored.
- Shift: on a qualified edge, shreg <= {shreg[4*NIBBLES-5:0], mosi_sync} and count increments.
- FSM IDLE: spi_w_sync=1 -> RECV with count=0. The edge in the same cycle as spi_w_sync rising is accepted.
- FSM RECV, normal edge: a qualified edge with count<NIBBLES-1 shifts.
- FSM RECV, final edge: a qualified edge with count==NIBBLES-1 completes the frame and moves to WAIT_END. The nibble is captured in the same cycle.
- FSM RECV, spi_w_sync=0: -> IDLE, partial frame discarded, count cleared. frame_err pulses only if count>=1; no pulse for count==0.
- FSM WAIT_END: all further edges are ignored (no shift, no error). spi_w_sync=0 -> IDLE.
- rx_busy=1 exactly while FSM=RECV.
- Frame completion, output free: if rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle, then rx_data <= completed frame (final nibble included) and rx_valid=1 from the next cycle.
- Frame completion, output occupied: if rx_valid=1 and rx_ready=0, the new frame is dropped, rx_data is unchanged, and overrun pulses the next cycle.
- Handshake: transfer occurs on a clk edge with rx_valid&rx_ready. rx_valid falls the next cycle unless a new frame loads in the same cycle, in which case it stays high.
- rx_data never changes while rx_valid=1 and rx_ready=0.
- Latency: the final mosi nibble at the spi_clk pin rising edge gives rx_valid high SYNC_STAGES+2 clk edges after the clk edge that first samples spi_clk high (4 with defaults).
- Timing requirement: spi_clk high and low phases must each be >= SYNC_STAGES+1 clk periods. Faster input is out of spec; behaviour is undefined but the block must not lock up.
- Reset mid-frame: everything returns to reset values immediately; any pending frame is lost.

Test Plan:
- Reset, then nibbles 3,A,5,5,A with spi_w high -> rx_data=0x3A55A, rx_valid=1 four clk edges after the last sampled spi_clk rise; rx_ready=1 -> rx_valid=0 the next cycle.
- Frame 0x12345 with rx_ready held 0, then second frame 0xFEDCB -> overrun pulses once, rx_data stays 0x12345; rx_ready=1 -> single transfer, rx_valid=0.
- rx_ready pulsed in the exact cycle frame 0x00001 completes while 0x12345 is valid -> 0x12345 transferred, rx_data=0x00001, rx_valid stays 1, no overrun.
- spi_w dropped after 3 nibbles (1,2,3) -> frame_err pulses 1 cycle, rx_valid stays 0. Next full frame 0xABCDE -> rx_data=0xABCDE.
- 7 spi_clk edges in one spi_w window, nibbles 1..7 -> rx_data=0x12345, extra edges ignored, no frame_err. spi_clk toggling with spi_w=0 -> no change.
- rst_n asserted after 2 nibbles -> all outputs 0 asynchronously. Next frame 0x0F0F0 -> received intact.
